// File: rtl/shower_pkg.sv
// -----------------------------------------------------------------------------
// shower_pkg
// Shared definitions for the anode shower window detector:
//   - shower_code_t : 2-bit shower classification (none/loose/nominal/tight)
//   - clog2()       : ceil(log2(value)), usable in constant expressions
//   - hist_entry_t  : one BX of window history {hit count, per-layer hit mask}
// -----------------------------------------------------------------------------
package shower_pkg;

  typedef enum logic [1:0] {
    SH_NONE    = 2'd0,
    SH_LOOSE   = 2'd1,
    SH_NOMINAL = 2'd2,
    SH_TIGHT   = 2'd3
  } shower_code_t;

  // ceil(log2(value)); clog2(1) = 0. Bounded loop so it folds at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Chamber geometry the history entry is sized for. The top-level
  // parameters default to these; retargeting the geometry means changing
  // them here so the history entry follows.
  localparam int NLY_DEF     = 6;
  localparam int NWG_DEF     = 112;
  localparam int HIST_CNT_W  = clog2(NLY_DEF * NWG_DEF + 1);
  localparam int HIST_MASK_W = NLY_DEF;

  typedef struct packed {
    logic [HIST_CNT_W-1:0]  cnt;   // popcount of all wire-group hits in one BX
    logic [HIST_MASK_W-1:0] mask;  // bit k set when layer k had any hit
  } hist_entry_t;

endpackage

// File: rtl/shower_popcnt.sv
// -----------------------------------------------------------------------------
// shower_popcnt
// Registered population count over N bits. Bits are first counted in small
// fixed groups, the group counts are then summed, and the total is registered.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the count
//   bits : N input bits
//   cnt  : registered number of set bits (W bits, cannot overflow)
// -----------------------------------------------------------------------------
module shower_popcnt
  import shower_pkg::*;
#(
  parameter int N = 672,
  parameter int W = clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bits,
  output logic [W-1:0] cnt
);

  localparam int GRP = 8;
  localparam int NG  = (N + GRP - 1) / GRP;
  localparam int GW  = clog2(GRP + 1);

  // Zero-extend so the last group is always full width.
  logic [NG*GRP-1:0] padded;
  logic [GW-1:0]     grp_cnt [NG];
  logic [W-1:0]      total;

  assign padded = (NG*GRP)'(bits);

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block, so no path can leave it holding its old value (which would
  // infer a latch).
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      grp_cnt[g] = '0;
      for (int b = 0; b < GRP; b++) begin
        grp_cnt[g] = grp_cnt[g] + GW'(padded[g*GRP + b]);
      end
    end
  end

  always_comb begin
    total = '0;
    for (int g = 0; g < NG; g++) begin
      total = total + W'(grp_cnt[g]);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= total;
  end

endmodule

// File: rtl/shower_window.sv
// -----------------------------------------------------------------------------
// shower_window
// Anode shower detector summing wire-group hits across a programmable sliding
// window of BX, with a minimum-layer cut, loose/nominal/tight thresholds and a
// programmable dead time. Fixed latency of DLY clocks from input sample to
// outputs, independent of the window depth.
//
// Pipeline (ly captured at edge t):
//   t+1 : total hit popcount and per-layer OR pushed into history (hist[0])
//   t+2 : window sum and window layer count over the newest eff_win entries
//   t+3 : classification plus dead-time suppression
//   then DLY-3 plain delay stages to the outputs
//
// Ports:
//   clk        : BX clock
//   rst        : synchronous active-high reset, clears all state
//   ly         : hit bits, layer k at [k*NWG +: NWG]
//   win_len    : window depth in BX; 0 acts as 1, >WIN_MAX acts as WIN_MAX
//   min_layers : layers required within the window; 0 always passes
//   th_loose   : window-sum threshold for loose
//   th_nominal : window-sum threshold for nominal
//   th_tight   : window-sum threshold for tight
//   dead_bx    : BX suppressed after an issued code; 0 disables
//   shower_int : shower code (0 none, 1 loose, 2 nominal, 3 tight)
//   shower_cnt : window hit sum aligned with shower_int
//   shower_nly : window layer count aligned with shower_int
// -----------------------------------------------------------------------------
module shower_window
  import shower_pkg::*;
#(
  parameter  int NLY     = NLY_DEF,
  parameter  int NWG     = NWG_DEF,
  parameter  int WIN_MAX = 4,
  parameter  int DLY     = 6,
  localparam int CW      = clog2(NLY * NWG + 1),
  localparam int SW      = CW + clog2(WIN_MAX),
  localparam int LW      = clog2(NLY + 1),
  localparam int WLW     = clog2(WIN_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NLY*NWG-1:0] ly,
  input  logic [WLW-1:0]   win_len,
  input  logic [LW-1:0]    min_layers,
  input  logic [SW-1:0]    th_loose,
  input  logic [SW-1:0]    th_nominal,
  input  logic [SW-1:0]    th_tight,
  input  logic [3:0]       dead_bx,
  output logic [1:0]       shower_int,
  output logic [SW-1:0]    shower_cnt,
  output logic [LW-1:0]    shower_nly
);

  localparam int NB = NLY * NWG;
  localparam int XD = DLY - 3;      // extra delay stages after classification
  localparam int OW = 2 + SW + LW;  // {code, sum, nly}

  // ---------------------------------------------------------------------------
  // Input capture (edge t)
  // ---------------------------------------------------------------------------
  logic [NB-1:0] ly_q;

  always_ff @(posedge clk) begin
    if (rst) ly_q <= '0;
    else     ly_q <= ly;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 (edge t+1): popcount and layer mask form the newest history entry
  // ---------------------------------------------------------------------------
  logic [CW-1:0]  pc_cnt;
  logic [NLY-1:0] mask_q;

  shower_popcnt #(
    .N (NB),
    .W (CW)
  ) u_popcnt (
    .clk  (clk),
    .rst  (rst),
    .bits (ly_q),
    .cnt  (pc_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      for (int k = 0; k < NLY; k++) begin
        mask_q[k] <= |ly_q[k*NWG +: NWG];
      end
    end
  end

  // hist[0] is the stage-1 register pair itself; older entries shift behind it.
  hist_entry_t hist [WIN_MAX];

  assign hist[0] = '{cnt: pc_cnt, mask: mask_q};

  generate
    if (WIN_MAX > 1) begin : g_hist
      hist_entry_t old_q [WIN_MAX-1];

      // NOTE: the history is deliberately cleared on reset: windows formed
      // right after reset must see zero-filled entries, not stale hits.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < WIN_MAX-1; i++) old_q[i] <= '0;
        end else begin
          old_q[0] <= hist[0];
          for (int i = 1; i < WIN_MAX-1; i++) old_q[i] <= old_q[i-1];
        end
      end

      for (genvar i = 1; i < WIN_MAX; i++) begin : g_tap
        assign hist[i] = old_q[i-1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 2 (edge t+2): window sum and window layer count
  // ---------------------------------------------------------------------------
  logic [WLW-1:0] eff_win;
  logic [SW-1:0]  sum_c;
  logic [NLY-1:0] mask_or;
  logic [LW-1:0]  nly_c;
  logic [SW-1:0]  sum2_q;
  logic [LW-1:0]  nly2_q;

  always_comb begin
    if (win_len == '0)                   eff_win = WLW'(1);
    else if (win_len > WLW'(WIN_MAX))    eff_win = WLW'(WIN_MAX);
    else                                 eff_win = win_len;
  end

  // Entries beyond eff_win stay in the history but are masked out here, so a
  // shrinking window takes effect on the very next edge.
  always_comb begin
    sum_c   = '0;
    mask_or = '0;
    for (int i = 0; i < WIN_MAX; i++) begin
      if (WLW'(i) < eff_win) begin
        sum_c   = sum_c + SW'(hist[i].cnt);
        mask_or = mask_or | hist[i].mask;
      end
    end
  end

  always_comb begin
    nly_c = '0;
    for (int k = 0; k < NLY; k++) begin
      nly_c = nly_c + LW'(mask_or[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum2_q <= '0;
      nly2_q <= '0;
    end else begin
      sum2_q <= sum_c;
      nly2_q <= nly_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 (edge t+3): classification and dead time
  // ---------------------------------------------------------------------------
  shower_code_t raw_code;
  shower_code_t code3_q;
  logic [SW-1:0] sum3_q;
  logic [LW-1:0] nly3_q;
  logic [3:0]    dead_q;

  // Fixed priority tight > nominal > loose, even when the thresholds are not
  // monotonic.
  always_comb begin
    raw_code = SH_NONE;
    if (nly2_q >= min_layers) begin
      if      (sum2_q >= th_tight)   raw_code = SH_TIGHT;
      else if (sum2_q >= th_nominal) raw_code = SH_NOMINAL;
      else if (sum2_q >= th_loose)   raw_code = SH_LOOSE;
    end
  end

  // An issued code reloads the dead counter; while it runs, codes are forced
  // to none, giving at least dead_bx+1 clocks between triggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      code3_q <= SH_NONE;
      sum3_q  <= '0;
      nly3_q  <= '0;
      dead_q  <= '0;
    end else begin
      sum3_q <= sum2_q;
      nly3_q <= nly2_q;
      if (dead_q != 4'd0) begin
        code3_q <= SH_NONE;
        dead_q  <= dead_q - 4'd1;
      end else begin
        code3_q <= raw_code;
        if (raw_code != SH_NONE) dead_q <= dead_bx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output delay line (DLY-3 stages)
  // ---------------------------------------------------------------------------
  logic [OW-1:0] s3_word;
  logic [OW-1:0] out_word;

  assign s3_word = {code3_q, sum3_q, nly3_q};

  generate
    if (XD > 0) begin : g_dly
      logic [OW-1:0] dl_q [XD];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < XD; i++) dl_q[i] <= '0;
        end else begin
          dl_q[0] <= s3_word;
          for (int i = 1; i < XD; i++) dl_q[i] <= dl_q[i-1];
        end
      end

      assign out_word = dl_q[XD-1];
    end else begin : g_nodly
      assign out_word = s3_word;
    end
  endgenerate

  assign {shower_int, shower_cnt, shower_nly} = out_word;

endmodule

// File: tb/tb_shower_window.sv
// -----------------------------------------------------------------------------
// tb_shower_window
// Self-checking bench for shower_window. Every BX's inputs are logged; the
// expected outputs for each cycle are rebuilt from that log by looking back
// over the captured BXs, so both the directed scenarios and the randomized
// run are checked cycle by cycle, with explicit constants at key points.
// -----------------------------------------------------------------------------
module tb_shower_window;
  import shower_pkg::*;

  localparam int NLY     = 6;
  localparam int NWG     = 112;
  localparam int WIN_MAX = 4;
  localparam int DLY     = 6;
  localparam int NB      = NLY * NWG;
  localparam int SW      = clog2(NB + 1) + clog2(WIN_MAX);
  localparam int LW      = clog2(NLY + 1);
  localparam int WLW     = clog2(WIN_MAX) + 1;
  localparam int NC      = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   ly;
  logic [WLW-1:0]  win_len;
  logic [LW-1:0]   min_layers;
  logic [SW-1:0]   th_loose, th_nominal, th_tight;
  logic [3:0]      dead_bx;
  logic [1:0]      shower_int;
  logic [SW-1:0]   shower_cnt;
  logic [LW-1:0]   shower_nly;

  always #5 clk = ~clk;

  shower_window #(
    .NLY     (NLY),
    .NWG     (NWG),
    .WIN_MAX (WIN_MAX),
    .DLY     (DLY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ly         (ly),
    .win_len    (win_len),
    .min_layers (min_layers),
    .th_loose   (th_loose),
    .th_nominal (th_nominal),
    .th_tight   (th_tight),
    .dead_bx    (dead_bx),
    .shower_int (shower_int),
    .shower_cnt (shower_cnt),
    .shower_nly (shower_nly)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Input log indexed by edge number and reference model
  // ---------------------------------------------------------------------------
  bit rst_a  [NC];
  int cnt_a  [NC];
  int mask_a [NC];
  int win_a  [NC];
  int minl_a [NC];
  int tl_a   [NC];
  int tn_a   [NC];
  int tt_a   [NC];
  int dbx_a  [NC];
  int c3_a   [NC];
  int s3_a   [NC];
  int n3_a   [NC];
  int dead_m = 0;
  int cyc    = 0;

  function automatic int eff_w(input int w);
    if (w == 0)       return 1;
    if (w > WIN_MAX)  return WIN_MAX;
    return w;
  endfunction

  // True if any edge in [a, b] had reset asserted (edges before 1 count as reset).
  function automatic bit rst_in(input int a, input int b);
    if (a < 1) return 1'b1;
    for (int k = a; k <= b; k++) if (rst_a[k]) return 1'b1;
    return 1'b0;
  endfunction

  // Window values latched at edge s2: BX captured at edge c enters the window
  // sum at edge c+2, and survives only if no reset hit it on the way.
  function automatic void window_at(input int s2, output int sum, output int nly);
    int m;
    sum = 0;
    nly = 0;
    m   = 0;
    if (s2 < 1 || rst_a[s2]) return;
    for (int i = 0; i < eff_w(win_a[s2]); i++) begin
      int c;
      c = s2 - 2 - i;
      if (c >= 1 && !rst_in(c, s2)) begin
        sum += cnt_a[c];
        m   |= mask_a[c];
      end
    end
    nly = $countones(m);
  endfunction

  // Classification and dead time decided at edge e.
  function automatic void classify_at(input int e);
    int s, n, raw;
    if (rst_a[e]) begin
      c3_a[e] = 0; s3_a[e] = 0; n3_a[e] = 0;
      dead_m  = 0;
      return;
    end
    window_at(e - 1, s, n);
    if (n < minl_a[e])       raw = 0;
    else if (s >= tt_a[e])   raw = 3;
    else if (s >= tn_a[e])   raw = 2;
    else if (s >= tl_a[e])   raw = 1;
    else                     raw = 0;
    s3_a[e] = s;
    n3_a[e] = n;
    if (dead_m > 0) begin
      c3_a[e] = 0;
      dead_m--;
    end else begin
      c3_a[e] = raw;
      if (raw != 0) dead_m = dbx_a[e];
    end
  endfunction

  // One clock: log the driven inputs, take the edge, compare against the model.
  task automatic step();
    int e, m, s3, xi, xs, xn;
    e = cyc + 1;
    if (e >= NC) begin
      $display("FAIL log_overflow: got %0d expected below %0d", e, NC);
      $fatal(1, "input log exhausted");
    end
    m = 0;
    for (int k = 0; k < NLY; k++) if (|ly[k*NWG +: NWG]) m |= (1 << k);
    rst_a[e]  = rst;
    cnt_a[e]  = $countones(ly);
    mask_a[e] = m;
    win_a[e]  = int'(win_len);
    minl_a[e] = int'(min_layers);
    tl_a[e]   = int'(th_loose);
    tn_a[e]   = int'(th_nominal);
    tt_a[e]   = int'(th_tight);
    dbx_a[e]  = int'(dead_bx);
    @(posedge clk);
    cyc = e;
    classify_at(e);
    s3 = e - (DLY - 3);
    if (rst_in(s3, e)) begin
      xi = 0; xs = 0; xn = 0;
    end else begin
      xi = c3_a[s3]; xs = s3_a[s3]; xn = n3_a[s3];
    end
    #1;
    check("mdl_int", 32'(shower_int), 32'(xi));
    check("mdl_cnt", 32'(shower_cnt), 32'(xs));
    check("mdl_nly", 32'(shower_nly), 32'(xn));
  endtask

  function automatic logic [NB-1:0] layer_hits(input int layer, input int n);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[layer*NWG + i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NB-1:0] rand_hits();
    logic [NB-1:0] v;
    v = '0;
    for (int k = 0; k < NLY; k++) begin
      case ($urandom_range(0, 4))
        1: for (int i = 0; i < NWG; i++) v[k*NWG + i] = ($urandom_range(0, 31) == 0);
        2: for (int i = 0; i < NWG; i++) v[k*NWG + i] = $urandom_range(0, 1) == 1;
        3: v[k*NWG +: NWG] = '1;
        4: for (int j = 0; j < int'($urandom_range(1, 10)); j++)
             v[k*NWG + int'($urandom_range(0, NWG-1))] = 1'b1;
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic flush(input int n);
    ly = '0;
    repeat (n) step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    ly         = '1;
    win_len    = WLW'(4);
    min_layers = LW'(5);
    th_loose   = SW'(10);
    th_nominal = SW'(20);
    th_tight   = SW'(30);
    dead_bx    = 4'd0;

    // Reset held with every wire hit.
    repeat (10) begin
      step();
      check("rst_hold_int", 32'(shower_int), 32'd0);
      check("rst_hold_cnt", 32'(shower_cnt), 32'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= DLY; k++) begin
      step();
      check("post_rst_zero_int", 32'(shower_int), 32'd0);
      check("post_rst_zero_cnt", 32'(shower_cnt), 32'd0);
    end
    step();
    check("post_rst_int", 32'(shower_int), 32'd3);
    check("post_rst_cnt", 32'(shower_cnt), 32'd672);
    flush(20);

    // Single BX, window of 1: 5 layers x 4 hits.
    win_len = WLW'(1);
    ly = '0;
    for (int k = 0; k < 5; k++) ly |= layer_hits(k, 4);
    step();
    ly = '0;
    repeat (DLY - 1) begin
      step();
      check("single_pre_int", 32'(shower_int), 32'd0);
    end
    step();
    check("single_int", 32'(shower_int), 32'd2);
    check("single_cnt", 32'(shower_cnt), 32'd20);
    check("single_nly", 32'(shower_nly), 32'd5);
    step();
    check("single_after_int", 32'(shower_int), 32'd0);
    flush(20);

    // Window of 3 over rotating layer pairs, then the same with a window of 1.
    for (int pass = 0; pass < 2; pass++) begin
      win_len = (pass == 0) ? WLW'(3) : WLW'(1);
      for (int b = 0; b < 3; b++) begin
        ly = layer_hits(2*b, 4) | layer_hits(2*b + 1, 4);
        step();
      end
      ly = '0;
      repeat (DLY - 2) step();
      step();
      if (pass == 0) begin
        check("win3_second_int", 32'(shower_int), 32'd0);
        step();
        check("win3_int", 32'(shower_int), 32'd2);
        check("win3_cnt", 32'(shower_cnt), 32'd24);
        check("win3_nly", 32'(shower_nly), 32'd6);
      end else begin
        step();
        check("win1_int", 32'(shower_int), 32'd0);
        check("win1_nly", 32'(shower_nly), 32'd2);
        check("win1_cnt", 32'(shower_cnt), 32'd8);
      end
      flush(20);
    end

    // Dead time 3 with continuous heavy hits.
    win_len = WLW'(1);
    dead_bx = 4'd3;
    ly = '0;
    for (int k = 0; k < NLY; k++) ly |= layer_hits(k, 40);
    step();
    repeat (DLY - 1) begin
      step();
      check("dead_pre_int", 32'(shower_int), 32'd0);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      check("dead_int", 32'(shower_int), (k % 4 == 0) ? 32'd3 : 32'd0);
    end
    dead_bx = 4'd0;
    flush(20);

    // Saturation: all wires on, window 4, then 7 (clamps) and 0 (acts as 1).
    win_len = WLW'(4);
    ly = '1;
    repeat (10) step();
    check("sat_cnt", 32'(shower_cnt), 32'd2688);
    check("sat_int", 32'(shower_int), 32'd3);
    check("sat_nly", 32'(shower_nly), 32'd6);
    win_len = WLW'(7);
    repeat (6) step();
    check("sat_win7_cnt", 32'(shower_cnt), 32'd2688);
    win_len = WLW'(0);
    repeat (6) step();
    check("sat_win0_cnt", 32'(shower_cnt), 32'd672);
    flush(20);

    // Layer cut.
    win_len = WLW'(1);
    ly = '0;
    for (int k = 0; k < 4; k++) ly |= layer_hits(k, 50);
    repeat (8) step();
    check("cut_min5_int", 32'(shower_int), 32'd0);
    check("cut_min5_nly", 32'(shower_nly), 32'd4);
    min_layers = LW'(4);
    repeat (8) step();
    check("cut_min4_int", 32'(shower_int), 32'd3);
    ly = layer_hits(0, 50);
    min_layers = LW'(0);
    repeat (8) step();
    check("cut_min0_int", 32'(shower_int), 32'd3);
    min_layers = LW'(5);
    flush(20);

    // Randomized run: hit patterns, controls and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        win_len    = WLW'($urandom_range(0, 7));
        min_layers = LW'($urandom_range(0, 7));
        th_loose   = SW'($urandom_range(0, 400));
        th_nominal = SW'($urandom_range(0, 900));
        th_tight   = SW'($urandom_range(0, 1600));
        dead_bx    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 99) == 0);
      ly  = rand_hits();
      step();
    end
    rst = 1'b0;
    flush(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
